// File: rtl/hazard_sched.sv
// Hazard/stall scheduler for a 5-stage non-forwarding RV32I pipeline.
// Optional perf counters are enabled with `define HAZARD_SCHED_PERF_EN.
module hazard_sched #(
    parameter int unsigned WB_WRITE_FIRST = 1,
    parameter int unsigned REG_AW         = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_vld_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic              id_use_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_is_rs2_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_rd_wren_i,
    input  logic              ex_redirect_i,
    output logic              stall_if_o,
    output logic              stall_id_o,
    output logic              bubble_ex_o,
    output logic              flush_ifid_o,
`ifdef HAZARD_SCHED_PERF_EN
    output logic [31:0]       perf_stall_cnt_o,
    output logic [31:0]       perf_flush_cnt_o,
`endif
    output logic [1:0]        state_o
);

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StStall = 2'd1,
        StFlush = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              sb_ex_vld_q, sb_mem_vld_q, sb_wb_vld_q;
    logic [REG_AW-1:0] sb_ex_rd_q, sb_mem_rd_q, sb_wb_rd_q;
    logic              sb_ex_vld_d;
    logic              hit_rs1, hit_rs2, hazard;

    function automatic logic src_match(input logic [REG_AW-1:0] rs,
                                       input logic ex_v, input logic [REG_AW-1:0] ex_rd,
                                       input logic mem_v, input logic [REG_AW-1:0] mem_rd,
                                       input logic wb_v, input logic [REG_AW-1:0] wb_rd);
        logic m;
        m = (ex_v && (ex_rd == rs)) || (mem_v && (mem_rd == rs));
        // With write-through regfile, WB's result is already visible to ID.
        if (WB_WRITE_FIRST == 0) begin
            m = m || (wb_v && (wb_rd == rs));
        end
        return (rs != '0) && m;
    endfunction

    always_comb begin
        hit_rs1 = src_match(id_rs1_i, sb_ex_vld_q, sb_ex_rd_q, sb_mem_vld_q, sb_mem_rd_q,
                            sb_wb_vld_q, sb_wb_rd_q);
        hit_rs2 = src_match(id_rs2_i, sb_ex_vld_q, sb_ex_rd_q, sb_mem_vld_q, sb_mem_rd_q,
                            sb_wb_vld_q, sb_wb_rd_q);
        hazard  = id_vld_i && ((id_use_rs1_i && hit_rs1) || (id_is_rs2_i && hit_rs2));
    end

    always_comb begin
        stall_if_o   = 1'b0;
        stall_id_o   = 1'b0;
        bubble_ex_o  = 1'b0;
        flush_ifid_o = 1'b0;
        state_d      = StRun;
        // Outputs are forced low while reset is held, even if redirect is high.
        if (!rst_i) begin
            if (ex_redirect_i) begin
                flush_ifid_o = 1'b1;
                bubble_ex_o  = 1'b1;
                state_d      = StFlush;
            end else if (hazard) begin
                stall_if_o  = 1'b1;
                stall_id_o  = 1'b1;
                bubble_ex_o = 1'b1;
                state_d     = StStall;
            end
        end
    end

    always_comb begin
        sb_ex_vld_d = 1'b0;
        if (!bubble_ex_o && id_vld_i) begin
            sb_ex_vld_d = id_rd_wren_i && (id_rd_i != '0);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StRun;
            sb_ex_vld_q  <= 1'b0;
            sb_mem_vld_q <= 1'b0;
            sb_wb_vld_q  <= 1'b0;
            sb_ex_rd_q   <= '0;
            sb_mem_rd_q  <= '0;
            sb_wb_rd_q   <= '0;
        end else begin
            state_q      <= state_d;
            sb_wb_vld_q  <= sb_mem_vld_q;
            sb_wb_rd_q   <= sb_mem_rd_q;
            sb_mem_vld_q <= sb_ex_vld_q;
            sb_mem_rd_q  <= sb_ex_rd_q;
            sb_ex_vld_q  <= sb_ex_vld_d;
            sb_ex_rd_q   <= id_rd_i;
        end
    end

    assign state_o = state_q;

`ifdef HAZARD_SCHED_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_if_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (flush_ifid_o && (flush_cnt_q != 32'hFFFF_FFFF)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign perf_stall_cnt_o = stall_cnt_q;
    assign perf_flush_cnt_o = flush_cnt_q;
`endif

endmodule
